// File: rtl/tas_ram_wr_ctrl.sv
// Read-side controller for the clk_50 temperature path: averages NUM_AVG FIFO
// samples and writes each truncated average to RAM at a descending address.
module tas_ram_wr_ctrl #(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 11,
    parameter int                NUM_AVG    = 4,
    parameter int                LOG2_AVG   = 2,
    parameter logic [ADDR_W-1:0] ADDR_START = ADDR_W'(2047)
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              ram_wr_n,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr
);

    localparam int ACC_W = DATA_W + LOG2_AVG;
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        SETUP,
        WR,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fifo_rd_q, fifo_rd_d;
    logic              ram_wr_n_q, ram_wr_n_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;

    // acc is LOG2_AVG bits wider than a sample, so the full sum never wraps.
    assign sum = acc_q + ACC_W'(fifo_data);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        fifo_rd_d  = 1'b0;
        ram_wr_n_d = 1'b1;
        ram_data_d = ram_data_q;
        ram_addr_d = ram_addr_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = RD;
                    fifo_rd_d = 1'b1;
                end
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                if (cnt_q == CNT_W'(NUM_AVG - 1)) begin
                    ram_data_d = sum[ACC_W-1:LOG2_AVG];
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = SETUP;
                end else begin
                    acc_d   = sum;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            SETUP: begin
                ram_wr_n_d = 1'b0;
                state_d    = WR;
            end
            WR: begin
                state_d = HOLD;
            end
            HOLD: begin
                // Address only moves after the hold cycle, so it is stable around the strobe.
                ram_addr_d = (ram_addr_q == '0) ? ADDR_START : ram_addr_q - ADDR_W'(1);
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            fifo_rd_q  <= 1'b0;
            ram_wr_n_q <= 1'b1;
            ram_data_q <= '0;
            ram_addr_q <= ADDR_START;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            fifo_rd_q  <= fifo_rd_d;
            ram_wr_n_q <= ram_wr_n_d;
            ram_data_q <= ram_data_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    assign fifo_rd  = fifo_rd_q;
    assign ram_wr_n = ram_wr_n_q;
    assign ram_data = ram_data_q;
    assign ram_addr = ram_addr_q;

endmodule

// File: doc/tas_ram_wr_ctrl.md
Name: tas_ram_wr_ctrl

Overview:
- Read-side controller for the temperature-averaging path in the clk_50 domain.
- Pops temperature bytes from the dual-clock FIFO (its read port) and accumulates NUM_AVG samples.
- Writes each truncated average to the external RAM with a setup/strobe/hold write cycle.
- RAM address descends from ADDR_START and wraps.

Parameters:
- DATA_W, 8: width of FIFO data, RAM data.
- ADDR_W, 11: RAM address width.
- NUM_AVG, 4: samples per average; power of two, at least 2.
- LOG2_AVG, 2: log2(NUM_AVG).
- ADDR_START, 2047: first write address; wrap reload value.

Ports:
- clk_50  in  1  50 MHz clock, sole clock.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO read-side empty flag.
- fifo_data  in  DATA_W  FIFO read data; valid the cycle after fifo_rd high (registered read).
- fifo_rd  out  1  FIFO pop strobe, one cycle per pop.
- ram_wr_n  out  1  RAM write strobe, active low.
- ram_data  out  DATA_W  RAM write data.
- ram_addr  out  ADDR_W  RAM write address.

Behaviour:
- One clock (clk_50). Reset is synchronous and active-high, sampled on the rising edge of clk_50. All outputs are registered.
- Reset values: state=IDLE, fifo_rd=0, ram_wr_n=1, ram_data=0, ram_addr=ADDR_START, acc=0, cnt=0.
- acc is DATA_W+LOG2_AVG bits wide, so it never overflows. cnt counts 0..NUM_AVG-1.
- IDLE: fifo_empty=0 sampled -> RD. Otherwise stay in IDLE.
- RD: fifo_rd=1 for exactly this cycle -> CAP.
- CAP: fifo_rd=0; fifo_data is valid this cycle.
  - cnt<NUM_AVG-1: acc<=acc+fifo_data, cnt++ -> IDLE.
  - cnt==NUM_AVG-1: ram_data<=(acc+fifo_data)>>LOG2_AVG (truncate), acc<=0, cnt<=0 -> SETUP.
- SETUP: ram_wr_n=1; ram_data and ram_addr are stable (one cycle of setup) -> WR.
- WR: ram_wr_n=0 for exactly one cycle -> HOLD.
- HOLD: ram_wr_n=1; data and address held (one cycle of hold). On exit: ram_addr<=ram_addr-1, except ram_addr==0 reloads ADDR_START -> IDLE.
- FIFO pop rules:
  - Throughput: 3 cycles per sample minimum; fifo_rd is never high in consecutive cycles.
  - fifo_rd is never asserted unless fifo_empty was 0 at the preceding edge.
  - No pops occur during SETUP, WR or HOLD; FIFO backlog waits.
- End-to-end latency: from the CAP edge of the final sample, ram_wr_n falls 2 cycles later (SETUP, then WR).
- ram_data and ram_addr change only on a CAP completion or HOLD exit, never while ram_wr_n=0.
- fifo_empty rising mid-average: controller idles in IDLE with partial acc and cnt retained; resumes on the next non-empty sample.
- Reset mid-operation, any state: at the next edge all outputs take reset values.
  - Partial accumulation is discarded.
  - An in-flight WR strobe is terminated (ram_wr_n=1).
  - A pop already issued is lost (FIFO data consumed, not counted).
- Reset together with fifo_empty=0: reset wins; no fifo_rd that cycle.

Test Plan:
- Basic average: FIFO supplies 10,20,30,40 -> fifo_rd pulses 4 times; ram_data=25 at ram_addr=0x7FF; ram_wr_n low exactly 1 cycle; data/addr stable one cycle before and after the strobe; ram_addr=0x7FE afterwards.
- Truncation/max: samples 1,1,1,2 -> ram_data=1. Samples 255,255,255,255 -> ram_data=255 (no overflow).
- Empty throttling: 2 samples, then fifo_empty=1 for 20 cycles, then samples 2,2 -> no fifo_rd and no write during the gap. Final write is (s1+s2+2+2)>>2.
- Address wrap: 2048 averages written -> last write at addr 0x000; next write at 0x7FF.
- Reset mid-accumulation: 3 samples of 100, reset for 1 cycle, then 8,8,8,8 -> single write ram_data=8 at 0x7FF.
- Reset during WR: assert reset in the WR cycle -> ram_wr_n=1 at the next edge; ram_addr=0x7FF; no further strobe.
